// File: rtl/srjk_reg_bank.sv
// srjk_reg_bank: bank of WIDTH independent edge-triggered bistable cells.
// Run-time mode selects SR, JK, D or T behaviour for every bit. Each bit also
// has a change pulse and a sticky SR-conflict flag. nq is always ~q.
module srjk_reg_bank #(
   parameter int               WIDTH   = 8,
   parameter logic [WIDTH-1:0] RST_VAL = '0,
   parameter int               SR_PRIO = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [1:0]       mode,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             err_clr,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] nq,
   output logic [WIDTH-1:0] chg,
   output logic [WIDTH-1:0] err,
   output logic             any_err
);

   typedef enum logic [1:0] {
      MODE_SR = 2'b00,
      MODE_JK = 2'b01,
      MODE_D  = 2'b10,
      MODE_T  = 2'b11
   } mode_t;

   mode_t            cur_mode;
   logic [WIDTH-1:0] qn;
   logic [WIDTH-1:0] conflict;
   logic [WIDTH-1:0] err_next;

   assign cur_mode = mode_t'(mode);

   // Per-bit next-state and SR-conflict detection for the selected mode
   always_comb begin
      qn       = q;
      conflict = '0;
      for (int unsigned i = 0; i < WIDTH; i++) begin
         unique case (cur_mode)
            MODE_SR: begin
               unique case ({a[i], b[i]})
                  2'b10: qn[i] = 1'b1;
                  2'b01: qn[i] = 1'b0;
                  2'b00: qn[i] = q[i];
                  2'b11: begin
                     conflict[i] = 1'b1;
                     if (SR_PRIO == 1)      qn[i] = 1'b1;
                     else if (SR_PRIO == 2) qn[i] = 1'b0;
                     else                   qn[i] = q[i];
                  end
               endcase
            end
            MODE_JK: begin
               unique case ({a[i], b[i]})
                  2'b10: qn[i] = 1'b1;
                  2'b01: qn[i] = 1'b0;
                  2'b00: qn[i] = q[i];
                  2'b11: qn[i] = ~q[i];
               endcase
            end
            MODE_D: qn[i] = a[i];
            MODE_T: qn[i] = a[i] ? ~q[i] : q[i];
         endcase
      end
   end

   // Sticky error update: clear first, then a same-edge conflict re-sets its bit
   always_comb begin
      err_next = err_clr ? '0 : err;
      if (en) err_next = err_next | conflict;
   end

   // Cell state, change pulses and error flags; reset overrides everything
   always_ff @(posedge clk) begin
      if (rst) begin
         q   <= RST_VAL;
         chg <= '0;
         err <= '0;
      end else begin
         if (en) begin
            q   <= qn;
            chg <= qn ^ q;
         end else begin
            chg <= '0;
         end
         err <= err_next;
      end
   end

   assign nq      = ~q;
   assign any_err = |err;

endmodule

// File: tb/tb_srjk_reg_bank.sv
// Directed self-checking bench for srjk_reg_bank. Three instances share
// stimulus and differ only in SR_PRIO (0 hold, 1 set wins, 2 reset wins).
module tb_srjk_reg_bank;

   localparam int WIDTH = 8;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             en = 1'b0;
   logic [1:0]       mode = 2'b00;
   logic [WIDTH-1:0] a = '0;
   logic [WIDTH-1:0] b = '0;
   logic             err_clr = 1'b0;

   logic [WIDTH-1:0] q0, nq0, chg0, err0;
   logic [WIDTH-1:0] q1, nq1, chg1, err1;
   logic [WIDTH-1:0] q2, nq2, chg2, err2;
   logic             any_err0, any_err1, any_err2;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   srjk_reg_bank #(.WIDTH(WIDTH), .RST_VAL(8'hA5), .SR_PRIO(0)) dut0 (
      .clk(clk), .rst(rst), .en(en), .mode(mode), .a(a), .b(b), .err_clr(err_clr),
      .q(q0), .nq(nq0), .chg(chg0), .err(err0), .any_err(any_err0));

   srjk_reg_bank #(.WIDTH(WIDTH), .RST_VAL(8'hA5), .SR_PRIO(1)) dut1 (
      .clk(clk), .rst(rst), .en(en), .mode(mode), .a(a), .b(b), .err_clr(err_clr),
      .q(q1), .nq(nq1), .chg(chg1), .err(err1), .any_err(any_err1));

   srjk_reg_bank #(.WIDTH(WIDTH), .RST_VAL(8'hA5), .SR_PRIO(2)) dut2 (
      .clk(clk), .rst(rst), .en(en), .mode(mode), .a(a), .b(b), .err_clr(err_clr),
      .q(q2), .nq(nq2), .chg(chg2), .err(err2), .any_err(any_err2));

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; en = 1'b1; mode = 2'b10; a = 8'hFF; b = 8'h00; err_clr = 1'b0;
      step();
      rst = 1'b0;
      n_checks++; if (q0 !== 8'hA5) begin n_fail++; $display("FAIL reset_q got %h exp %h", q0, 8'hA5); end
      n_checks++; if (nq0 !== 8'h5A) begin n_fail++; $display("FAIL reset_nq got %h exp %h", nq0, 8'h5A); end
      n_checks++; if (chg0 !== 8'h00) begin n_fail++; $display("FAIL reset_chg got %h exp %h", chg0, 8'h00); end
      n_checks++; if (err0 !== 8'h00) begin n_fail++; $display("FAIL reset_err got %h exp %h", err0, 8'h00); end
      n_checks++; if (any_err0 !== 1'b0) begin n_fail++; $display("FAIL reset_any_err got %b exp %b", any_err0, 1'b0); end
   endtask

   task automatic test_sr();
      mode = 2'b10; a = 8'h00; step();
      n_checks++; if (chg0 !== 8'hA5) begin n_fail++; $display("FAIL d_load_chg got %h exp %h", chg0, 8'hA5); end
      mode = 2'b00; a = 8'h0F; b = 8'h00; step();
      n_checks++; if (q0 !== 8'h0F) begin n_fail++; $display("FAIL sr_set_q got %h exp %h", q0, 8'h0F); end
      n_checks++; if (chg0 !== 8'h0F) begin n_fail++; $display("FAIL sr_set_chg got %h exp %h", chg0, 8'h0F); end
      a = 8'h03; b = 8'h03; step();
      n_checks++; if (q0 !== 8'h0F) begin n_fail++; $display("FAIL sr_conf_q got %h exp %h", q0, 8'h0F); end
      n_checks++; if (chg0 !== 8'h00) begin n_fail++; $display("FAIL sr_conf_chg got %h exp %h", chg0, 8'h00); end
      n_checks++; if (err0 !== 8'h03) begin n_fail++; $display("FAIL sr_conf_err got %h exp %h", err0, 8'h03); end
      n_checks++; if (any_err0 !== 1'b1) begin n_fail++; $display("FAIL sr_conf_any got %b exp %b", any_err0, 1'b1); end
      n_checks++; if (nq0 !== 8'hF0) begin n_fail++; $display("FAIL sr_conf_nq got %h exp %h", nq0, 8'hF0); end
      err_clr = 1'b1; a = 8'h00; b = 8'h80; step();
      err_clr = 1'b0;
      n_checks++; if (err0 !== 8'h00) begin n_fail++; $display("FAIL sr_clr_err got %h exp %h", err0, 8'h00); end
      n_checks++; if (any_err0 !== 1'b0) begin n_fail++; $display("FAIL sr_clr_any got %b exp %b", any_err0, 1'b0); end
      n_checks++; if (q0 !== 8'h0F) begin n_fail++; $display("FAIL sr_clr_q got %h exp %h", q0, 8'h0F); end
   endtask

   task automatic test_priority();
      mode = 2'b10; a = 8'h0F; b = 8'h00; err_clr = 1'b1; step();
      err_clr = 1'b0;
      n_checks++; if (q2 !== 8'h0F) begin n_fail++; $display("FAIL prio_load_q2 got %h exp %h", q2, 8'h0F); end
      mode = 2'b00; a = 8'hFF; b = 8'hFF; step();
      n_checks++; if (q0 !== 8'h0F) begin n_fail++; $display("FAIL prio0_q got %h exp %h", q0, 8'h0F); end
      n_checks++; if (err0 !== 8'hFF) begin n_fail++; $display("FAIL prio0_err got %h exp %h", err0, 8'hFF); end
      n_checks++; if (q1 !== 8'hFF) begin n_fail++; $display("FAIL prio1_q got %h exp %h", q1, 8'hFF); end
      n_checks++; if (err1 !== 8'hFF) begin n_fail++; $display("FAIL prio1_err got %h exp %h", err1, 8'hFF); end
      n_checks++; if (chg1 !== 8'hF0) begin n_fail++; $display("FAIL prio1_chg got %h exp %h", chg1, 8'hF0); end
      n_checks++; if (nq1 !== 8'h00) begin n_fail++; $display("FAIL prio1_nq got %h exp %h", nq1, 8'h00); end
      n_checks++; if (q2 !== 8'h00) begin n_fail++; $display("FAIL prio2_q got %h exp %h", q2, 8'h00); end
      n_checks++; if (err2 !== 8'hFF) begin n_fail++; $display("FAIL prio2_err got %h exp %h", err2, 8'hFF); end
      n_checks++; if (chg2 !== 8'h0F) begin n_fail++; $display("FAIL prio2_chg got %h exp %h", chg2, 8'h0F); end
   endtask

   task automatic test_jk_t();
      mode = 2'b10; a = 8'h0F; b = 8'h00; step();
      n_checks++; if (chg0 !== 8'h00) begin n_fail++; $display("FAIL d_same_chg got %h exp %h", chg0, 8'h00); end
      mode = 2'b01; a = 8'hFF; b = 8'hFF; step();
      n_checks++; if (q0 !== 8'hF0) begin n_fail++; $display("FAIL jk_tog_q got %h exp %h", q0, 8'hF0); end
      n_checks++; if (chg0 !== 8'hFF) begin n_fail++; $display("FAIL jk_tog_chg got %h exp %h", chg0, 8'hFF); end
      n_checks++; if (err0 !== 8'hFF) begin n_fail++; $display("FAIL jk_err_kept got %h exp %h", err0, 8'hFF); end
      a = 8'h0C; b = 8'h30; step();
      n_checks++; if (q0 !== 8'hCC) begin n_fail++; $display("FAIL jk_setrst_q got %h exp %h", q0, 8'hCC); end
      mode = 2'b10; a = 8'hF0; b = 8'h00; step();
      mode = 2'b11; a = 8'h81; step();
      n_checks++; if (q0 !== 8'h71) begin n_fail++; $display("FAIL t_tog_q got %h exp %h", q0, 8'h71); end
      n_checks++; if (chg0 !== 8'h81) begin n_fail++; $display("FAIL t_tog_chg got %h exp %h", chg0, 8'h81); end
   endtask

   task automatic test_enable_clear();
      en = 1'b0; mode = 2'b10; a = 8'h55; b = 8'h00;
      for (int i = 0; i < 3; i++) begin
         err_clr = (i == 0);
         step();
         n_checks++; if (q0 !== 8'h71) begin n_fail++; $display("FAIL en0_q cyc %0d got %h exp %h", i, q0, 8'h71); end
         n_checks++; if (chg0 !== 8'h00) begin n_fail++; $display("FAIL en0_chg cyc %0d got %h exp %h", i, chg0, 8'h00); end
      end
      err_clr = 1'b0;
      n_checks++; if (err0 !== 8'h00) begin n_fail++; $display("FAIL en0_errclr got %h exp %h", err0, 8'h00); end
      en = 1'b0; mode = 2'b00; a = 8'hFF; b = 8'hFF; step();
      n_checks++; if (err0 !== 8'h00) begin n_fail++; $display("FAIL en0_no_conf got %h exp %h", err0, 8'h00); end
      en = 1'b1; a = 8'h03; b = 8'h03; step();
      n_checks++; if (err0 !== 8'h03) begin n_fail++; $display("FAIL race_pre_err got %h exp %h", err0, 8'h03); end
      a = 8'h10; b = 8'h10; err_clr = 1'b1; step();
      err_clr = 1'b0;
      n_checks++; if (err0 !== 8'h10) begin n_fail++; $display("FAIL race_err got %h exp %h", err0, 8'h10); end
      n_checks++; if (any_err0 !== 1'b1) begin n_fail++; $display("FAIL race_any got %b exp %b", any_err0, 1'b1); end
      n_checks++; if (q0 !== 8'h71) begin n_fail++; $display("FAIL race_q got %h exp %h", q0, 8'h71); end
   endtask

   task automatic test_reset_mid();
      en = 1'b1; mode = 2'b11; a = 8'hFF; b = 8'h00; step();
      n_checks++; if (q0 !== 8'h8E) begin n_fail++; $display("FAIL mid_tog_q got %h exp %h", q0, 8'h8E); end
      rst = 1'b1; step();
      rst = 1'b0;
      n_checks++; if (q0 !== 8'hA5) begin n_fail++; $display("FAIL mid_rst_q got %h exp %h", q0, 8'hA5); end
      n_checks++; if (chg0 !== 8'h00) begin n_fail++; $display("FAIL mid_rst_chg got %h exp %h", chg0, 8'h00); end
      n_checks++; if (err0 !== 8'h00) begin n_fail++; $display("FAIL mid_rst_err got %h exp %h", err0, 8'h00); end
      step();
      n_checks++; if (q0 !== 8'h5A) begin n_fail++; $display("FAIL post_rst_q got %h exp %h", q0, 8'h5A); end
      n_checks++; if (nq0 !== 8'hA5) begin n_fail++; $display("FAIL post_rst_nq got %h exp %h", nq0, 8'hA5); end
      n_checks++; if (chg0 !== 8'hFF) begin n_fail++; $display("FAIL post_rst_chg got %h exp %h", chg0, 8'hFF); end
   endtask

   initial begin
      #1;
      test_reset();
      test_sr();
      test_priority();
      test_jk_t();
      test_enable_clear();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout got running exp finished");
      $fatal(1, "timeout");
   end

endmodule
